data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder serving the MEM-stage load/store port of the pipelined MIPS core. Accepts one word/half/byte load or store at a time, inserts a programmable number of wait states, and holds the pipeline via `Stall` until the access completes. Performs byte-lane steering, sign/zero extension and alignment checking. Replaces the single-cycle data memory so slower backing storage can be modelled.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the internal array; power of two.
- `WAIT_STATES`, 2: number of BUSY cycles per access; range 0–15.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Address` in 32: byte address from EX/MEM ALU result.
- `WriteData` in 32: store data; a half-word store uses bits [15:0], a byte store uses bits [7:0].
- `MemRead` in 1: load request.
- `MemWrite` in 1: store request.
- `DataMemChoice` in 2: access size. 00 = word, 01 = half, 10 = byte, 11 = treated as word.
- `RegisterLoadChoice` in 2: load extension. 00 = sign-extend; any other value = zero-extend.
- `ReadData` out 32: load result, registered.
- `Stall` out 1: holds PC, IF/ID, ID/EX and EX/MEM while high.
- `Ready` out 1: one-cycle completion strobe.
- `AddrError` out 1: one-cycle strobe, coincident with `Ready`, for a faulted access.

## Operation
- Request = `MemRead` | `MemWrite`. If both are high, the access is a store.
- The requester holds `Address`, `WriteData` and the control inputs stable while `Stall` is 1.
- FSM states and transitions:
  - IDLE:
    - Request → BUSY with counter = `WAIT_STATES`.
    - If `WAIT_STATES` = 0, request → DONE.
  - BUSY:
    - Counter decrements each cycle.
    - When the counter reaches 1 → DONE.
    - If the request drops → IDLE. This is an abort: no write, no strobe.
  - DONE: one cycle, then → IDLE unconditionally.
- `Stall` = request && state ≠ DONE (combinational). `Ready` = (state == DONE).
- Word index = `Address[31:2]`. Byte order is little-endian: lane 0 = bits [7:0].
- Fault conditions: word access with `Address[1:0]` ≠ 0; half access with `Address[0]` = 1; word index ≥ `DEPTH_WORDS`.
- On a fault: no write, `ReadData` loads 0, `AddrError` = 1 in DONE.
- Store: only the addressed byte lanes are updated, at the rising edge that ends DONE.
- Load: the selected lanes are extended per `RegisterLoadChoice` and registered into `ReadData` on entry to DONE. `ReadData` holds that value until the next completed load.
- A store does not change `ReadData`.

## Timing
- Reset values: state IDLE, `ReadData` = 0, `Ready` = 0, `AddrError` = 0. `Stall` follows its combinational equation.
- Memory contents are not cleared by reset.
- Request first seen in cycle 0 → DONE in cycle `WAIT_STATES`+1.
- `Stall` is high in cycles 0 through `WAIT_STATES` and low in the DONE cycle. The pipeline advances at the edge ending DONE.
- Back-to-back accesses: a new request in the cycle after DONE starts a fresh access. Throughput is one access per `WAIT_STATES`+2 cycles.
- Reset asserted mid-access: the FSM goes to IDLE immediately, the pending store is discarded, and no strobe is issued.
- Request-field changes while BUSY are illegal, except full deassertion, which is an abort.

## Configuration
- `DMR_ACCESS_COUNT_EN` defined:
  - Adds output ports `LoadCount` [15:0] and `StoreCount` [15:0].
  - Each counter increments in the DONE cycle of a completed, non-faulted load or store respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- `DMR_ACCESS_COUNT_EN` undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Word store, then word load: `WAIT_STATES`=2, store 32'hDEADBEEF at 0x10, then load 0x10.
  - `Stall` high for 3 cycles on each access.
  - `Ready` pulses in cycle 3.
  - `ReadData` = 32'hDEADBEEF.
- Byte lanes: store byte 8'h80 at 0x13, then load byte at 0x13.
  - With `RegisterLoadChoice`=00: `ReadData` = 32'hFFFFFF80.
  - With `RegisterLoadChoice`=01: `ReadData` = 32'h00000080.
  - A word load of 0x10 returns 32'h80ADBEEF.
- Faults:
  - Half load at 0x11 → `AddrError` and `Ready` pulse together, `ReadData` = 0.
  - Word store at 0x4 × `DEPTH_WORDS` leaves memory unchanged.
- Abort and reset:
  - Drop `MemWrite` in BUSY → no write, no `Ready`.
  - Assert `Reset` low in BUSY → IDLE, `ReadData` = 0, and a subsequent load returns the prior contents.
- `WAIT_STATES`=0 back-to-back: two consecutive loads.
  - Each has a 1-cycle `Stall`, `Ready` in cycle 1, and one IDLE cycle between them.
  - With `DMR_ACCESS_COUNT_EN` defined: `LoadCount` = 2 and `StoreCount` = 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle MEM-stage data memory with wait states, lane steering and fault checks.
// Optional: define DMR_ACCESS_COUNT_EN to add LoadCount/StoreCount outputs.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  DataMemChoice,
    input  logic [1:0]  RegisterLoadChoice,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Ready,
    output logic        AddrError
`ifdef DMR_ACCESS_COUNT_EN
    ,
    output logic [15:0] LoadCount,
    output logic [15:0] StoreCount
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        req;
    logic        sz_half, sz_byte;
    logic        misalign, out_of_range, fault;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word, rd_shift, load_val;
    logic        sext;
    logic [3:0]  byte_en;
    logic [31:0] wr_lanes;
    logic        enter_done;
    logic        err_q, store_q;
    logic        mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    assign req     = MemRead | MemWrite;
    assign sz_half = (DataMemChoice == 2'b01);
    assign sz_byte = (DataMemChoice == 2'b10);
    assign sext    = (RegisterLoadChoice == 2'b00);

    always_comb begin
        misalign = 1'b0;
        unique case (1'b1)
            sz_byte: misalign = 1'b0;
            sz_half: misalign = Address[0];
            default: misalign = |Address[1:0];
        endcase
    end

    assign out_of_range = {2'b00, Address[31:2]} >= DEPTH_U;
    assign fault        = misalign | out_of_range;
    assign word_idx     = Address[AW+1:2];
    assign rd_word      = mem[word_idx];
    assign rd_shift     = rd_word >> {Address[1:0], 3'b000};

    always_comb begin
        load_val = rd_word;
        byte_en  = 4'b1111;
        wr_lanes = WriteData;
        unique case (1'b1)
            sz_byte: begin
                load_val = {{24{sext & rd_shift[7]}}, rd_shift[7:0]};
                byte_en  = 4'b0001 << Address[1:0];
                wr_lanes = {4{WriteData[7:0]}};
            end
            sz_half: begin
                load_val = {{16{sext & rd_shift[15]}}, rd_shift[15:0]};
                byte_en  = 4'b0011 << Address[1:0];
                wr_lanes = {2{WriteData[15:0]}};
            end
            default: begin
                load_val = rd_word;
                byte_en  = 4'b1111;
                wr_lanes = WriteData;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = 4'(WAIT_STATES);
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt <= 4'd1) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_done = (state_nxt == DONE) && (state != DONE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ReadData <= 32'd0;
            err_q    <= 1'b0;
            store_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_done) begin
                err_q   <= fault;
                store_q <= MemWrite;
                if (!MemWrite) begin
                    ReadData <= fault ? 32'd0 : load_val;
                end
            end
        end
    end

    assign Ready     = (state == DONE);
    assign AddrError = Ready & err_q;
    assign Stall     = req && (state != DONE);

    // Store commits on the edge that ends DONE; address/data are held until then.
    assign mem_we = Ready & store_q & ~err_q;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

`ifdef DMR_ACCESS_COUNT_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            LoadCount  <= 16'd0;
            StoreCount <= 16'd0;
        end else if (Ready && !err_q) begin
            if (store_q) begin
                if (StoreCount != 16'hFFFF) begin
                    StoreCount <= StoreCount + 16'd1;
                end
            end else if (LoadCount != 16'hFFFF) begin
                LoadCount <= LoadCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, abort/reset sequences,
// zero-wait back-to-back, and random traffic against a byte-level model.
module tb_data_mem_responder;

    localparam int DEPTH0 = 1024;
    localparam int DEPTH1 = 64;
    localparam int WAIT0  = 2;
    localparam int WAIT1  = 0;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Address [2];
    logic [31:0] WriteData [2];
    logic        MemRead [2];
    logic        MemWrite [2];
    logic [1:0]  DataMemChoice [2];
    logic [1:0]  RegisterLoadChoice [2];
    logic [31:0] ReadData [2];
    logic        Stall [2];
    logic        Ready [2];
    logic        AddrError [2];
`ifdef DMR_ACCESS_COUNT_EN
    logic [15:0] LoadCount [2];
    logic [15:0] StoreCount [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_STATES(WAIT0)) u_dut0 (
        .Clk(Clk), .Reset(Reset),
        .Address(Address[0]), .WriteData(WriteData[0]),
        .MemRead(MemRead[0]), .MemWrite(MemWrite[0]),
        .DataMemChoice(DataMemChoice[0]),
        .RegisterLoadChoice(RegisterLoadChoice[0]),
        .ReadData(ReadData[0]), .Stall(Stall[0]),
        .Ready(Ready[0]), .AddrError(AddrError[0])
`ifdef DMR_ACCESS_COUNT_EN
        , .LoadCount(LoadCount[0]), .StoreCount(StoreCount[0])
`endif
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH1), .WAIT_STATES(WAIT1)) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .Address(Address[1]), .WriteData(WriteData[1]),
        .MemRead(MemRead[1]), .MemWrite(MemWrite[1]),
        .DataMemChoice(DataMemChoice[1]),
        .RegisterLoadChoice(RegisterLoadChoice[1]),
        .ReadData(ReadData[1]), .Stall(Stall[1]),
        .Ready(Ready[1]), .AddrError(AddrError[1])
`ifdef DMR_ACCESS_COUNT_EN
        , .LoadCount(LoadCount[1]), .StoreCount(StoreCount[1])
`endif
    );

    typedef struct {
        bit          st;
        logic [1:0]  sz;
        logic [1:0]  ext;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    // Reference memory: one byte per entry, keyed by {dut, byte address}.
    bit [7:0] ref_mem [longint];

    function automatic int wait_of(int d);
        return (d == 0) ? WAIT0 : WAIT1;
    endfunction

    function automatic int depth_of(int d);
        return (d == 0) ? DEPTH0 : DEPTH1;
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        if (sz == 2'b01) return 2;
        if (sz == 2'b10) return 1;
        return 4;
    endfunction

    function automatic longint key(int d, longint a);
        return (longint'(d) << 32) | a;
    endfunction

    function automatic bit ref_fault(int d, logic [1:0] sz, logic [31:0] a);
        longint ua = longint'(a);
        int n = nbytes(sz);
        return ((ua % n) != 0) || ((ua / 4) >= depth_of(d));
    endfunction

    function automatic logic [31:0] ref_load(int d, logic [1:0] sz,
                                             logic [1:0] ext, logic [31:0] a);
        longint v = 0;
        int n = nbytes(sz);
        if (ref_fault(d, sz, a)) return 32'd0;
        for (int i = 0; i < n; i++)
            v = v + (longint'(ref_mem[key(d, longint'(a) + i)]) << (8 * i));
        if (ext == 2'b00 && n < 4 && v[8*n-1])
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(int d, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        int n = nbytes(sz);
        if (!ref_fault(d, sz, a))
            for (int i = 0; i < n; i++)
                ref_mem[key(d, longint'(a) + i)] = 8'(wd >> (8 * i));
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input int d, input bit st, input bit both,
                          input logic [1:0] sz, input logic [1:0] ext,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int stalls, output int rcyc,
                          output logic err, output logic [31:0] rd);
        Address[d]            = a;
        WriteData[d]          = wd;
        DataMemChoice[d]      = sz;
        RegisterLoadChoice[d] = ext;
        MemWrite[d]           = st;
        MemRead[d]            = !st || both;
        stalls = 0;
        rcyc   = -1;
        err    = 1'b0;
        rd     = 32'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (Stall[d]) stalls++;
            if (Ready[d]) begin
                rcyc = k;
                err  = AddrError[d];
                rd   = ReadData[d];
                break;
            end
            @(posedge Clk);
            #1;
        end
        if (rcyc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no Ready on dut%0d within 40 cycles", d);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int d);
        MemRead[d]  = 1'b0;
        MemWrite[d] = 1'b0;
        @(negedge Clk);
        chk("ready_one_cycle", 32'(Ready[d]), 32'd0);
        @(posedge Clk);
        #1;
    endtask

    task automatic run_vec(input int d, input vec_t v, input bit both);
        int stalls, rcyc;
        logic err;
        logic [31:0] rd;
        access(d, v.st, both, v.sz, v.ext, v.addr, v.wd, stalls, rcyc, err, rd);
        chk("stall_cycles", 32'(stalls), 32'(wait_of(d) + 1));
        chk("ready_cycle", 32'(rcyc), 32'(wait_of(d) + 1));
        chk("addr_error", 32'(err), 32'(v.err));
        if (!v.st) chk("read_data", rd, v.rd);
        idle(d);
    endtask

    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, rcyc;
        logic err;
        logic [31:0] rd;
        vec_t v;

        tbl[0]  = '{1'b1, 2'b00, 2'b00, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'b00, 2'b00, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 2'b10, 2'b00, 32'h13,   32'h12345680, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 2'b10, 2'b00, 32'h13,   32'h0,        1'b0, 32'hFFFFFF80};
        tbl[4]  = '{1'b0, 2'b10, 2'b01, 32'h13,   32'h0,        1'b0, 32'h00000080};
        tbl[5]  = '{1'b0, 2'b00, 2'b00, 32'h10,   32'h0,        1'b0, 32'h80ADBEEF};
        tbl[6]  = '{1'b0, 2'b01, 2'b00, 32'h11,   32'h0,        1'b1, 32'h0};
        tbl[7]  = '{1'b1, 2'b00, 2'b00, 32'h0,    32'h11223344, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 2'b00, 2'b00, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 2'b00, 2'b00, 32'h0,    32'h0,        1'b0, 32'h11223344};
        tbl[10] = '{1'b1, 2'b01, 2'b00, 32'h12,   32'h9999ABCD, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 2'b01, 2'b00, 32'h12,   32'h0,        1'b0, 32'hFFFFABCD};
        tbl[12] = '{1'b0, 2'b01, 2'b11, 32'h12,   32'h0,        1'b0, 32'h0000ABCD};
        tbl[13] = '{1'b0, 2'b00, 2'b00, 32'h10,   32'h0,        1'b0, 32'hABCDBEEF};
        tbl[14] = '{1'b1, 2'b11, 2'b00, 32'h20,   32'h01020304, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 2'b00, 2'b00, 32'h22,   32'hFFFFFFFF, 1'b1, 32'h0};
        tbl[16] = '{1'b0, 2'b11, 2'b10, 32'h20,   32'h0,        1'b0, 32'h01020304};

        for (int d = 0; d < 2; d++) begin
            Address[d] = '0; WriteData[d] = '0;
            MemRead[d] = 1'b0; MemWrite[d] = 1'b0;
            DataMemChoice[d] = '0; RegisterLoadChoice[d] = '0;
        end

        #1 Reset = 1'b0;
        #11;
        for (int d = 0; d < 2; d++) begin
            chk("reset_read_data", ReadData[d], 32'd0);
            chk("reset_ready", 32'(Ready[d]), 32'd0);
            chk("reset_addr_error", 32'(AddrError[d]), 32'd0);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        foreach (tbl[i]) run_vec(0, tbl[i], 1'b0);

        // Abort: store dropped during BUSY must not commit or strobe.
        Address[0] = 32'h20; WriteData[0] = 32'hFFFFFFFF;
        DataMemChoice[0] = 2'b00; MemRead[0] = 1'b0; MemWrite[0] = 1'b1;
        @(negedge Clk);
        chk("abort_stall_c0", 32'(Stall[0]), 32'd1);
        @(posedge Clk);
        #1;
        MemWrite[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            chk("abort_no_ready", 32'(Ready[0]), 32'd0);
            @(posedge Clk);
            #1;
        end
        run_vec(0, tbl[16], 1'b0);

        // Reset mid-store: ReadData cleared, store discarded, no strobe.
        Address[0] = 32'h20; WriteData[0] = 32'hCAFEF00D;
        DataMemChoice[0] = 2'b00; MemRead[0] = 1'b0; MemWrite[0] = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        chk("midreset_read_data", ReadData[0], 32'd0);
        chk("midreset_ready", 32'(Ready[0]), 32'd0);
        MemWrite[0] = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk);
            #1;
            @(negedge Clk);
            chk("midreset_no_ready", 32'(Ready[0]), 32'd0);
        end
        @(posedge Clk);
        #1;
        run_vec(0, tbl[16], 1'b0);

        // Zero wait states, two loads back to back with request held high.
        for (int k = 0; k < 2; k++) begin
            access(1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h40 + 32'(4 * k), 32'h0,
                   stalls, rcyc, err, rd);
            chk("b2b_stall_cycles", 32'(stalls), 32'd1);
            chk("b2b_ready_cycle", 32'(rcyc), 32'd1);
            chk("b2b_addr_error", 32'(err), 32'd0);
        end
        idle(1);
`ifdef DMR_ACCESS_COUNT_EN
        chk("b2b_load_count", 32'(LoadCount[1]), 32'd2);
        chk("b2b_store_count", 32'(StoreCount[1]), 32'd0);
`endif

        // Random traffic on both instances against the byte model.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                v = '{1'b1, 2'b00, 2'b00, 32'h40 + 32'(4 * w), $urandom, 1'b0, 32'h0};
                run_vec(d, v, 1'b0);
                ref_store(d, v.sz, v.addr, v.wd);
            end
            for (int n = 0; n < 80; n++) begin
                v.st   = 1'($urandom_range(0, 1));
                v.sz   = 2'($urandom_range(0, 3));
                v.ext  = 2'($urandom_range(0, 3));
                v.wd   = $urandom;
                if ($urandom_range(0, 7) == 0)
                    v.addr = 32'(4 * depth_of(d)) + 32'($urandom_range(0, 63));
                else
                    v.addr = 32'h40 + 32'($urandom_range(0, 63));
                v.err = ref_fault(d, v.sz, v.addr);
                v.rd  = v.st ? 32'h0 : ref_load(d, v.sz, v.ext, v.addr);
                run_vec(d, v, 1'($urandom_range(0, 1)));
                if (v.st) ref_store(d, v.sz, v.addr, v.wd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
